// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared constants and types for the multiplier scheduler slice.
//   MULT_LATENCY : register stages inside `multiplication`
//   OP_W / PROD_W: operand and product widths
//   rsp_entry_t  : response FIFO entry {requester id, product}
//   tag_t        : in-flight tracking tag {valid, requester id}
// -----------------------------------------------------------------------------
package calc_pkg;
  localparam int MULT_LATENCY = 2;
  localparam int OP_W         = 8;
  localparam int PROD_W       = 16;

  typedef struct packed {
    logic              id;
    logic [PROD_W-1:0] product;
  } rsp_entry_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/mult_rsp_fifo.sv
// -----------------------------------------------------------------------------
// mult_rsp_fifo
//   Synchronous FIFO of rsp_entry_t with occupancy count.
//   Ports: clk, rst_n (async, active low), push/push_data, pop (ignored when
//   empty), head (entry at read pointer), count (0..DEPTH).
//   DEPTH must be a power of two so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module mult_rsp_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rsp_entry_t             push_data,
  input  logic                   pop,
  output rsp_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = 1;
  localparam logic [PTR_W:0]     CNT_ONE  = 1;
  localparam logic [PTR_W:0]     CNT_FULL = (PTR_W+1)'(DEPTH);

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ; // idle, or push and pop together: occupancy unchanged
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset (it is only a few entries) so the head
  // reads as zero straight out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Upstream credit accounting must make this unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_FULL)));
endmodule

// File: rtl/multiplication.sv
// -----------------------------------------------------------------------------
// multiplication
//   Unsigned 8x8 -> 16 multiplier with two register stages and no stall.
//   Ports: clk, a/b operands in, product out (valid two edges after a/b).
//   The pipeline registers are deliberately unreset; stale contents are
//   harmless because users track validity outside this block.
// -----------------------------------------------------------------------------
module multiplication (
  input  logic        clk,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);
  logic [7:0]  a_q, b_q;
  logic [15:0] product_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    a_q       <= a;
    b_q       <= b;
    product_q <= 16'(a_q) * 16'(b_q);
  end

  assign product = product_q;
endmodule

// File: rtl/mult_scheduler.sv
// -----------------------------------------------------------------------------
// mult_scheduler
//   Shares one pipelined `multiplication` between two requesters.
//   Ports: req0_*/req1_* valid/ready operand channels, rsp_* valid/ready
//   result channel carrying requester id and 16-bit product.
//   Round-robin arbitration registers the winner's operands; a tag pipe
//   follows each operation through the multiplier and pushes the result
//   into a response FIFO. Issue is credit-limited (FIFO count plus tags in
//   flight) because the multiplier cannot be stalled.
//   LATENCY must match the register depth of `multiplication`.
// -----------------------------------------------------------------------------
module mult_scheduler
  import calc_pkg::*;
#(
  parameter int LATENCY    = MULT_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [PROD_W-1:0] rsp_product
);
  logic [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic            rr_last_q, rr_last_d;   // 1: req1 won most recently
  tag_t            tag_q [LATENCY+1];
  tag_t            tag_d [LATENCY+1];

  logic [PROD_W-1:0]            mult_product;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  rsp_entry_t                   fifo_head;
  rsp_entry_t                   push_entry;
  int                           inflight;
  int                           credit_sum;
  logic                         credit_ok, grant0, grant1, hs0, hs1;

  always_comb begin
    // A pop in this cycle is not counted: credit only ever lags, never leads.
    inflight = 0;
    for (int k = 0; k <= LATENCY; k++) if (tag_q[k].valid) inflight++;
    credit_sum = int'(fifo_count) + inflight;
    credit_ok  = credit_sum < FIFO_DEPTH;

    grant0 = req0_valid && (!req1_valid || rr_last_q);
    grant1 = req1_valid && (!req0_valid || !rr_last_q);
    // rst_n gating keeps both readys low while reset is asserted.
    req0_ready = rst_n && credit_ok && grant0;
    req1_ready = rst_n && credit_ok && grant1;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;

    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rr_last_d = rr_last_q;
    tag_d[0]  = '0;
    if (hs0) begin
      op_a_d    = req0_a;
      op_b_d    = req0_b;
      rr_last_d = 1'b0;
      tag_d[0]  = '{valid: 1'b1, id: 1'b0};
    end else if (hs1) begin
      op_a_d    = req1_a;
      op_b_d    = req1_b;
      rr_last_d = 1'b1;
      tag_d[0]  = '{valid: 1'b1, id: 1'b1};
    end
    for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];

    push_entry = '{id: tag_q[LATENCY].id, product: mult_product};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      rr_last_q <= 1'b1;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rr_last_q <= rr_last_d;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end

  multiplication u_mult (
    .clk     (clk),
    .a       (op_a_q),
    .b       (op_b_q),
    .product (mult_product)
  );

  mult_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_q[LATENCY].valid),
    .push_data (push_entry),
    .pop       (rsp_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign rsp_valid   = fifo_count != '0;
  assign rsp_id      = fifo_head.id;
  assign rsp_product = fifo_head.product;
endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Shares one pipelined `multiplication` instance (8x8 to 16-bit, two internal register stages) between two requesters, req0 and req1.
- Arbitrates round-robin and registers the winning operands into the multiplier.
- Tracks in-flight operations with a tag shift pipe and buffers products in a small response FIFO.
- The multiplier cannot stall, so issue is credit-limited: every result is guaranteed buffer space.

Parameters:
- LATENCY, 2: clock edges from operand-register load until the multiplier product is valid (matches `multiplication`).
- FIFO_DEPTH, 4: number of response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  8  requester 0 multiplicand
- req0_b  in  8  requester 0 multiplier
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a  in  8  requester 1 multiplicand
- req1_b  in  8  requester 1 multiplier
- rsp_valid  out  1  FIFO head holds a result
- rsp_ready  in  1  consumer takes the head
- rsp_id  out  1  requester that issued the head result (0/1)
- rsp_product  out  16  unsigned product a*b

Behaviour:
- Reset, asynchronous on rst_n low:
  - tag pipe cleared, FIFO emptied, rr_last = 1 (req0 wins first), operand registers = 0.
  - Outputs during and after reset: rsp_valid=0, rsp_id=0, rsp_product=0, req0_ready=0, req1_ready=0.
- Credit:
  - credit_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = number of valid tags in the pipe.
  - A same-cycle pop is not credited.
- Arbitration, combinational each cycle, gated by credit_ok:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to rr_last.
  - reqN_ready = credit_ok & grantN. At most one ready is high per cycle.
  - A handshake is reqN_valid & reqN_ready.
  - The ready/grant value does not depend on the requester holding valid over multiple cycles; requesters must hold operands stable until ready.
- Issue, on a handshake edge:
  - op_a / op_b registers load the granted operands.
  - tag[0] = {valid=1, id}; rr_last = id.
  - With no handshake, tag[0].valid = 0 and the operand registers hold their value.
- Pipe:
  - tag[k] shifts to tag[k+1] every cycle for k = 0..LATENCY-1.
  - The multiplier inputs are driven directly from op_a / op_b.
  - When tag[LATENCY].valid = 1, the multiplier product is valid that cycle. On the next edge, {tag id, product} is written into the FIFO.
- Latency:
  - Empty FIFO: handshake at edge E0 gives rsp_valid=1 in the cycle after edge E0+LATENCY+1, i.e. 3 cycles. There is no bypass.
  - Throughput: one issue per cycle while credit lasts.
- FIFO:
  - Pop when rsp_valid & rsp_ready.
  - Simultaneous push and pop on the same edge is legal; count stays unchanged.
  - Push when full is impossible by the credit rule; assert it in simulation.
  - Results leave in issue order.
  - rsp_id / rsp_product show the head entry, registered-storage read.
- Boundaries:
  - Full FIFO with rsp_ready=0 drops both readys within the cycle that credit_ok falls. Pending requests wait with no loss.
  - Pointer wrap-around at FIFO_DEPTH must be correct.
  - Arithmetic is unsigned. 255*255 = 16'hFE01 with no overflow.
- Reset mid-operation discards in-flight tags. Stale products from the multiplier's unreset internal registers are never pushed, because the tag pipe is cleared.

Decomposition:
- Shared package `calc_pkg`:
  - MULT_LATENCY = 2.
  - Operand width = 8, product width = 16.
  - Typedef for the response entry {id, product[15:0]}.
- Sub-modules:
  - Instantiate the existing `multiplication` unmodified.
  - One new sub-module `mult_rsp_fifo`: synchronous FIFO of 17-bit entries with count output, async active-low reset.

Test Plan:
- Single op: req0 a=12, b=13 held until ready; rsp_ready=1 → req0_ready high the first cycle; rsp_valid 3 cycles later with id=0, product=156; then rsp_valid drops.
- Contention: both valid every cycle, req0 (7,9), req1 (255,255) → grants alternate 0,1,0,1 starting with 0; responses 63 (id 0), 65025 (id 1), alternating, in order.
- Backpressure: rsp_ready=0, req0 streaming a=i, b=2 → exactly 4 handshakes, then req0_ready=0 indefinitely. Raising rsp_ready drains 0,2,4,6 and issue resumes. No loss or duplication over 20 ops.
- Simultaneous push/pop at full-minus-one with wrap across 3 FIFO laps → order and count stay correct; the push-when-full assertion never fires.
- Reset mid-flight: issue 2 ops, assert rst_n low for 1 cycle on the cycle after issue → all outputs 0 immediately; no response appears afterwards. A next op (3,5) returns 15 with id=0.
- Edge operands: (0,200)=0, (1,255)=255, (128,2)=256, (255,255)=65025.
